// File: rtl/execute_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
package execute_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } muldiv_state_t;

   function automatic logic is_signed_op(input muldiv_op_t op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step.
module muldiv_step #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_div,
   input  logic [DATA_WIDTH-1:0] i_acc,
   input  logic [DATA_WIDTH-1:0] i_part,
   input  logic [DATA_WIDTH-1:0] i_b,
   output logic [DATA_WIDTH-1:0] o_acc,
   output logic [DATA_WIDTH-1:0] o_part
);

   localparam int W = DATA_WIDTH;

   logic [W:0]   w_sum;
   logic [W:0]   w_shl;
   logic [W+1:0] w_diff;

   // Multiply: {acc,part} is the product register, multiplier in part.
   // Divide: acc is the partial remainder, part shifts dividend out/quotient in.
   assign w_sum  = {1'b0, i_acc} + ({1'b0, i_b} & {(W+1){i_part[0]}});
   assign w_shl  = {i_acc, i_part[W-1]};
   assign w_diff = {1'b0, w_shl} - {2'b00, i_b};

   always_comb begin
      o_acc  = w_sum[W:1];
      o_part = {w_sum[0], i_part[W-1:1]};
      if (i_div) begin
         if (!w_diff[W+1]) begin
            o_acc  = W'(w_diff);
            o_part = {i_part[W-2:0], 1'b1};
         end else begin
            o_acc  = w_shl[W-1:0];
            o_part = {i_part[W-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// EXECUTE_FAST_MUL_EN: multiplies use a combinational multiplier (latency 1).
module execute_muldiv
   import execute_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_E,
   input  logic                  valid_E,
   input  logic                  flush_E,
   input  logic [2:0]            MulDivOp_E,
   input  logic [DATA_WIDTH-1:0] opA_E,
   input  logic [DATA_WIDTH-1:0] opB_E,
   output logic [DATA_WIDTH-1:0] result_E,
   output logic                  done_E,
   output logic                  stall_E
);

   localparam int W = DATA_WIDTH;

   muldiv_state_t          r_state;
   muldiv_op_t             r_op;
   logic [COUNT_WIDTH-1:0] r_cnt;
   logic [W-1:0]           r_acc;
   logic [W-1:0]           r_part;
   logic [W-1:0]           r_b;
   logic [W-1:0]           r_result;
   logic                   r_neg_q;
   logic                   r_neg_r;

   muldiv_op_t   w_op;
   logic         w_go;
   logic         w_a_neg;
   logic         w_b_neg;
   logic [W-1:0] w_a_mag;
   logic [W-1:0] w_b_mag;
   logic         w_neg_q;
   logic         w_neg_r;
   logic [W-1:0] w_acc_n;
   logic [W-1:0] w_part_n;
   logic         w_last;

   function automatic logic [W-1:0] fix_result(
      input muldiv_op_t   op,
      input logic [W-1:0] hi,
      input logic [W-1:0] lo,
      input logic         neg_q,
      input logic         neg_r
   );
      logic [2*W-1:0] p;
      logic [W-1:0]   q;
      logic [W-1:0]   r;
      p = neg_q ? -{hi, lo} : {hi, lo};
      q = neg_q ? -lo : lo;
      r = neg_r ? -hi : hi;
      if (op[2] && op[1]) return r;
      else if (op[2])     return q;
      else if (op == OP_MUL) return p[W-1:0];
      else                return p[2*W-1:W];
   endfunction

   assign w_op    = muldiv_op_t'(MulDivOp_E);
   assign w_go    = (r_state == S_IDLE) & start_E & valid_E & ~flush_E;
   assign w_a_neg = is_signed_op(w_op) & opA_E[W-1];
   assign w_b_neg = is_signed_op(w_op) & (w_op != OP_MULHSU) & opB_E[W-1];
   assign w_a_mag = w_a_neg ? -opA_E : opA_E;
   assign w_b_mag = w_b_neg ? -opB_E : opB_E;
   // A zero divisor keeps the all-ones quotient unsigned.
   assign w_neg_q = (w_a_neg ^ w_b_neg) & (~w_op[2] | (|opB_E));
   assign w_neg_r = w_a_neg;
   assign w_last  = (r_cnt == COUNT_WIDTH'(W-1));

`ifdef EXECUTE_FAST_MUL_EN
   logic [2*W-1:0] w_prod;
   assign w_prod = {{W{1'b0}}, w_a_mag} * {{W{1'b0}}, w_b_mag};
`endif

   muldiv_step #(.DATA_WIDTH(W)) u_step (
      .i_div  (r_op[2]),
      .i_acc  (r_acc),
      .i_part (r_part),
      .i_b    (r_b),
      .o_acc  (w_acc_n),
      .o_part (w_part_n)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_op     <= OP_MUL;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_part   <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_go) begin
                  r_op    <= w_op;
                  r_acc   <= '0;
                  r_part  <= w_a_mag;
                  r_b     <= w_b_mag;
                  r_neg_q <= w_neg_q;
                  r_neg_r <= w_neg_r;
                  r_cnt   <= '0;
                  r_state <= S_BUSY;
`ifdef EXECUTE_FAST_MUL_EN
                  if (!w_op[2]) begin
                     r_state  <= S_DONE;
                     r_result <= fix_result(w_op, w_prod[2*W-1:W],
                                            w_prod[W-1:0], w_neg_q, w_neg_r);
                  end
`endif
               end
            end
            S_BUSY: begin
               if (flush_E) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_acc  <= w_acc_n;
                  r_part <= w_part_n;
                  r_cnt  <= r_cnt + 1'b1;
                  if (w_last) begin
                     r_state  <= S_DONE;
                     r_result <= fix_result(r_op, w_acc_n, w_part_n,
                                            r_neg_q, r_neg_r);
                  end
               end
            end
            S_DONE: begin
               r_state  <= S_IDLE;
               r_cnt    <= '0;
               r_result <= '0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign done_E   = (r_state == S_DONE) & ~flush_E;
   assign result_E = done_E ? r_result : '0;
   assign stall_E  = w_go | (r_state == S_BUSY);

endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench for execute_muldiv: directed ops, edge cases, aborts.
module tb_execute_muldiv;
   import execute_pkg::*;

`ifdef EXECUTE_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_E = 1'b0;
   logic        valid_E = 1'b0;
   logic        flush_E = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] result_E;
   logic        done_E;
   logic        stall_E;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   n_done = 0;

   execute_muldiv dut (
      .clk        (clk),
      .rst        (rst),
      .start_E    (start_E),
      .valid_E    (valid_E),
      .flush_E    (flush_E),
      .MulDivOp_E (op),
      .opA_E      (a),
      .opB_E      (b),
      .result_E   (result_E),
      .done_E     (done_E),
      .stall_E    (stall_E)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && done_E) begin
         n_done++;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done_E=1 result %h, expected none (cycle %0d)",
                     result_E, cyc);
         end else begin
            e = q.pop_front();
            chk("result", result_E, e.res);
            chk("latency", cyc, e.cyc);
         end
      end
   end

   // Entered and left just after a rising edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] r,
                        input bit stall_chk);
      int c;
      int lat;
      lat = o[2] ? DIV_LAT : MUL_LAT;
      c = cyc;
      op = o; a = x; b = y;
      start_E = 1'b1; valid_E = 1'b1;
      q.push_back('{r, c + lat});
      #1;
      if (stall_chk) chk("stall_start", stall_E, 1);
      for (int i = 0; i < 45; i++) begin
         @(posedge clk); #1;
         start_E = 1'b0; valid_E = 1'b0;
         if (q.size() == 0) break;
         if (stall_chk) chk("stall_busy", stall_E, (cyc < c + lat) ? 1 : 0);
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: got no done_E for op %0d, expected one", o);
         q.delete();
      end
   endtask

   task automatic abort(input bit use_rst, input int at);
      int d;
      op = OP_DIV; a = 32'hFFFFFFF9; b = 32'd2;
      start_E = 1'b1; valid_E = 1'b1;
      for (int i = 0; i < at; i++) begin
         @(posedge clk); #1;
         start_E = 1'b0; valid_E = 1'b0;
      end
      d = n_done;
      if (use_rst) rst = 1'b1;
      else flush_E = 1'b1;
      #1;
      chk("abort_done", done_E, 0);
      if (use_rst) begin
         chk("rst_stall", stall_E, 0);
         chk("rst_result", result_E, 0);
      end
      @(posedge clk); #1;
      rst = 1'b0; flush_E = 1'b0;
      chk("abort_stall_after", stall_E, 0);
      repeat (40) @(posedge clk);
      #1;
      chk("abort_no_done", n_done, d);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1);
   end

   initial begin : stim
      int d;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_done", done_E, 0);
      chk("reset_stall", stall_E, 0);
      chk("reset_result", result_E, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      issue(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1);
      issue(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
      issue(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
      issue(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      issue(OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 1'b0);
      issue(OP_MULH,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0);
      issue(OP_MULHU,  32'h80000000, 32'h00000002, 32'h00000001, 1'b0);
      issue(OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b1);
      issue(OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
      issue(OP_DIVU,   32'd100,      32'd7,        32'd14,       1'b0);
      issue(OP_REMU,   32'd100,      32'd7,        32'd2,        1'b0);
      issue(OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b0);
      issue(OP_REM,    32'd5,        32'd0,        32'd5,        1'b0);
      issue(OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b0);
      issue(OP_REMU,   32'd5,        32'd0,        32'd5,        1'b0);
      issue(OP_DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b0);
      issue(OP_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b0);
      issue(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
      issue(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);

      abort(1'b0, 10);
      abort(1'b1, 10);
      issue(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
      abort(1'b0, 33);

      d = n_done;
      op = OP_DIVU; a = 32'd9; b = 32'd3;
      start_E = 1'b1; valid_E = 1'b1; flush_E = 1'b1;
      #1;
      chk("flush_blocks_start_stall", stall_E, 0);
      @(posedge clk); #1;
      start_E = 1'b0; valid_E = 1'b0; flush_E = 1'b0;
      chk("flush_blocks_start_idle", stall_E, 0);
      repeat (40) @(posedge clk);
      #1;
      chk("flush_blocks_start_nodone", n_done, d);

      d = n_done;
      op = OP_DIVU; a = 32'd100; b = 32'd7;
      start_E = 1'b1; valid_E = 1'b1;
      q.push_back('{32'd14, cyc + DIV_LAT});
      for (int i = 1; i < 45; i++) begin
         @(posedge clk); #1;
         if (i == 5 || i == 20) begin
            op = OP_DIV; a = 32'd5; b = 32'd0;
            start_E = 1'b1; valid_E = 1'b1;
         end else begin
            start_E = 1'b0; valid_E = 1'b0;
         end
      end
      start_E = 1'b0; valid_E = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL ignore_start_timeout: got no done_E, expected one");
         q.delete();
      end
      chk("ignore_start_one_done", n_done, d + 1);

      issue(OP_REMU,   32'd100,      32'd7,        32'd2,        1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
- Execute-stage unit for RV32M-style multiply/divide; sits beside the single-cycle ALU in the execute stage.
- Iterative radix-2 engine: one operation in flight at a time.
- Holds the pipeline through `stall_E` while busy.
- Presents the result for one cycle, qualified by `done_E`.

Parameters:
- DATA_WIDTH, 32, operand/result width (even, >=8)
- COUNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start_E  input  1  request new operation; only meaningful when valid_E=1
- valid_E  input  1  execute-stage instruction valid
- flush_E  input  1  abort in-flight op (branch mispredict/jump)
- MulDivOp_E  input  3  operation code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- opA_E  input  DATA_WIDTH  rs1 value
- opB_E  input  DATA_WIDTH  rs2 value
- result_E  output  DATA_WIDTH  result; valid only while done_E=1
- done_E  output  1  one-cycle result strobe
- stall_E  output  1  hold PC/fetch/decode/execute registers

Behaviour:
- Reset (async): state=IDLE, counter=0, all internal registers 0; result_E=0, done_E=0, stall_E=0.
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY when start_E & valid_E & !flush_E.
  - Capture op and |A|, |B| (signed ops take magnitudes; the MULHSU B operand is unsigned).
  - Capture result-sign flags.
  - Clear counter.
- BUSY:
  - One shift-add (multiply) or shift-subtract (restoring divide) step per cycle.
  - Counter increments each cycle.
  - After DATA_WIDTH steps -> DONE.
- DONE:
  - done_E=1 for exactly one cycle; result_E sign-corrected.
  - Next state is IDLE.
- Latency: start cycle = cycle 0; done_E high in cycle DATA_WIDTH+1 (33 for default).
- stall_E is combinational: (IDLE & start_E & valid_E & !flush_E) | BUSY. It is low in DONE, so the pipeline advances and consumes result_E that cycle.
- start_E while BUSY or DONE is ignored; no queueing.
- Multiply result selection:
  - 2*DATA_WIDTH product.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - Negation is applied to the full double-width product.
- Divide by zero:
  - DIV/DIVU quotient = all ones.
  - REM/REMU = opA (unmodified).
  - Takes the full latency; no early exit.
- Signed overflow (opA=most-negative, opB=-1):
  - DIV = most-negative.
  - REM = 0.
- flush_E:
  - In BUSY or DONE: next state IDLE, done_E suppressed (0 that cycle if in DONE), counter cleared.
  - In IDLE: blocks start.
- Simultaneous flush_E & start_E: flush wins, no operation starts.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no done_E is ever produced for the aborted op.
- Remainder sign follows the dividend; quotient is negated when the operand signs differ (signed ops only).

Optional Feature:
- Macro: EXECUTE_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU use a combinational multiplier.
  - FSM goes IDLE -> DONE directly; done_E one cycle after start (latency 1).
  - stall_E is asserted only in the start cycle.
  - Divide ops are unchanged (DATA_WIDTH+1).
- Undefined: all ops are iterative as above. Results are bit-identical either way.

Decomposition:
- Package execute_pkg holds:
  - muldiv_op_t enum (3-bit codes above)
  - muldiv_state_t enum (IDLE, BUSY, DONE)
  - helper function is_signed_op
- One sub-module, muldiv_step: combinational single iteration.
  - Inputs: mode, accumulator, partial operand, B.
  - Outputs: next accumulator/quotient bits.
  - The FSM, counter, sign capture/correction and stall logic stay in execute_muldiv.

Test Plan:
- MUL opA=7, opB=0xFFFFFFFD (-3), start at cycle 0:
  - stall_E=1 cycles 0..32.
  - done_E=1 only in cycle 33 with result_E=0xFFFFFFEB.
  - stall_E=0 in cycle 33.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- Edge cases:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
  - All of these at full latency.
- Aborts:
  - Start DIV, assert flush_E at cycle 10 -> IDLE next cycle, stall_E=0, no done_E within 40 cycles.
  - Repeat with rst at cycle 10 -> outputs 0 immediately.
  - A new MUL started afterwards completes correctly.
- Concurrent and back-to-back requests:
  - start_E pulses during BUSY are ignored: only one done_E, first operands' result.
  - Back-to-back ops (new start in the cycle after DONE) both complete.
  - With EXECUTE_FAST_MUL_EN, the MUL test gives done_E at cycle 1 with the same value.
